sram_rw_array_init: RTL

- Parametrised single-port (1RW) synchronous SRAM behavioural model with byte-lane write masking.
- Intended as the next-generation drop-in for cache data/tag arrays.
- Adds over the plain SRAM model: synchronous reset, a hardware zero-init sweep FSM, a software re-init request, a ready/rvalid handshake, deterministic dout0 (never X), and optional write readback.
- Sits between the cache controller and its storage.

---
 rtl/sram_rw_array_init.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sram_rw_array_init.sv
// sram_rw_array_init: single-port (1RW) synchronous SRAM model with byte-lane
// write masking, a zero-init sweep FSM (after reset or on init0), a
// ready/rvalid handshake and optional write readback. Storage is split into
// one sram_rw_lane instance per write-mask lane.

// One write-mask lane of the array: GRAN bits wide, DEPTH words deep.
// rdata is the pre-edge contents of the addressed word.
module sram_rw_lane #(
    parameter int GRAN       = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [GRAN-1:0]       wdata,
    output logic [GRAN-1:0]       rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [GRAN-1:0] mem [DEPTH];

    // Lane write: commits at the edge, so a read on the next cycle sees it.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

module sram_rw_array_init #(
    parameter  int DATA_WIDTH     = 256,
    parameter  int ADDR_WIDTH     = 4,
    parameter  int WMASK_GRAN     = 8,
    parameter  int WRITE_READBACK = 0,
    localparam int NUM_WMASKS     = DATA_WIDTH / WMASK_GRAN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic                  init0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  rvalid0,
    output logic                  ready0
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int STAGES = 1;
    // ptr carries one spare bit so the last-word compare is unambiguous.
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_bad_gran
        $fatal(1, "DATA_WIDTH must be a multiple of WMASK_GRAN");
    end

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // Accepted request for this cycle (rd/wr never both set).
    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
    } req_t;

    state_t                                   state, state_nxt;
    logic [ADDR_WIDTH:0]                      ptr, ptr_nxt;
    logic                                     sweep_we;
    logic                                     sweep_go;
    req_t                                     req;
    logic                                     acc_vld;
    logic [STAGES-1:0]                        vld_q;
    logic [STAGES:0]                          vld_pipe;
    logic [DATA_WIDTH-1:0]                    dout_q;

    logic [NUM_WMASKS-1:0][WMASK_GRAN-1:0]    din_lanes;
    logic [NUM_WMASKS-1:0][WMASK_GRAN-1:0]    lane_wdata;
    logic [NUM_WMASKS-1:0][WMASK_GRAN-1:0]    lane_rdata;
    logic [NUM_WMASKS-1:0][WMASK_GRAN-1:0]    lane_merged;
    logic [NUM_WMASKS-1:0]                    lane_we;
    logic [ADDR_WIDTH-1:0]                    lane_addr;

    assign din_lanes = din0;

    // State and sweep pointer; reset restarts the sweep from word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next state: sweep one word per cycle, leave INIT after the last word.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sweep_we  = 1'b0;
        unique case (state)
            ST_INIT: begin
                sweep_we = 1'b1;
                ptr_nxt  = ptr + PTR_ONE;
                if (ptr == PTR_LAST) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = '0;
                end
            end
            ST_IDLE: begin
                if (init0) begin
                    state_nxt = ST_INIT;
                    ptr_nxt   = '0;
                end
            end
        endcase
    end

    assign sweep_go = sweep_we & ~rst;
    assign ready0   = (state == ST_IDLE);

    // Request acceptance: only in IDLE, and init0 or reset drop the request.
    always_comb begin
        req      = '0;
        req.addr = addr0;
        if (!rst && state == ST_IDLE && !init0 && !csb0) begin
            req.rd = web0;
            req.wr = ~web0;
        end
    end

    // Lane port mux: the sweep owns every lane while it runs.
    always_comb begin
        lane_addr = sweep_go ? ptr[ADDR_WIDTH-1:0] : req.addr;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            lane_we[i]    = sweep_go | (req.wr & wmask0[i]);
            lane_wdata[i] = sweep_go ? '0 : din_lanes[i];
        end
    end

    for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_lane
        sram_rw_lane #(
            .GRAN       (WMASK_GRAN),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .addr  (lane_addr),
            .wdata (lane_wdata[g]),
            .rdata (lane_rdata[g])
        );
        // Post-write word: new data in masked lanes, old contents elsewhere.
        assign lane_merged[g] = wmask0[g] ? din_lanes[g] : lane_rdata[g];
    end

    assign acc_vld  = req.rd | (req.wr & (WRITE_READBACK != 0));
    assign vld_pipe = {vld_q, acc_vld};

    // Response valid pipeline: one-cycle latency for reads and readbacks.
    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_pipe[STAGES-1:0];
    end

    // Output data: only moves on reset or a response, so it is never X.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (req.rd) begin
            dout_q <= lane_rdata;
        end else if (req.wr && WRITE_READBACK != 0) begin
            dout_q <= lane_merged;
        end
    end

    assign dout0   = dout_q;
    assign rvalid0 = vld_pipe[STAGES];
endmodule
